// File: rtl/rr_arbiter_pkg.sv
// rtl/rr_arbiter_pkg.sv - shared types and constants for the round-robin arbiter
//
// Contents:
//   N_MAX      largest supported channel count
//   CNT_W      width of the optional grant-hold counter
//   state_e    arbiter FSM state (IDLE: no grant, GRANT: one channel granted)
//   idx_width  index width for a given channel count

package rr_arbiter_pkg;

  localparam int N_MAX = 16;
  localparam int CNT_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotate-priority search for the round-robin arbiter
//
// Parameters:
//   N       number of request channels
//   PW      index width
// Ports:
//   req     in   N   request vector
//   ptr     in   PW  channel where the search starts
//   found   out  1   some request bit is set
//   idx     out  PW  binary index of the winner, 0 when none
//   onehot  out  N   one-hot winner, 0 when none

module rr_pick
  import rr_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          found,
  output logic [PW-1:0] idx,
  output logic [N-1:0]  onehot
);

  // Walk the channels starting at ptr, wrapping past N-1; the first set bit wins.
  always_comb begin
    int c;
    logic [PW-1:0] c_idx;
    c      = 0;
    c_idx  = '0;
    found  = 1'b0;
    idx    = '0;
    onehot = '0;
    for (int i = 0; i < N; i++) begin
      c = int'(ptr) + i;
      if (c >= N) begin
        c = c - N;
      end
      c_idx = PW'(c);
      if (!found && req[c_idx]) begin
        found         = 1'b1;
        idx           = c_idx;
        onehot[c_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with registered one-hot grant
//
// Optional feature macro: RR_ARBITER_TIMEOUT_EN (grant-hold limit with timeout pulse).
//
// Parameters:
//   N          number of request channels (2..16)
//   TIMEOUT    grant-hold limit in cycles (2..255), only used with the macro
// Ports:
//   clk        in   1         clock, rising edge
//   rst        in   1         asynchronous active-high reset
//   req        in   N         per-channel level request
//   ack        in   1         grant holder consumed its grant
//   grant      out  N         one-hot grant, 0 when idle
//   grant_idx  out  clog2(N)  index of granted channel, 0 when idle
//   valid      out  1         grant is non-zero
//   timeout    out  1         one-cycle pulse on forced revocation

module rr_arbiter
  import rr_arbiter_pkg::*;
#(
  parameter int N       = 4,
  parameter int TIMEOUT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 ack,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 valid,
  output logic                 timeout
);

  localparam int PW = $clog2(N);

  if (N < 2 || N > N_MAX || TIMEOUT < 2 || TIMEOUT > 255) begin : g_param_check
    $error("rr_arbiter: N or TIMEOUT out of range");
  end

  state_e        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [PW-1:0] grant_idx_q, grant_idx_d;
  logic          valid_q, valid_d;

  logic          pick_found;
  logic [PW-1:0] pick_idx;
  logic [N-1:0]  pick_onehot;
  logic [PW-1:0] ptr_inc;

`ifdef RR_ARBITER_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`endif

  rr_pick #(
    .N  (N),
    .PW (PW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .found  (pick_found),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  // Channel after the current holder, wrapping at N-1 (N need not be a power of two).
  assign ptr_inc = (grant_idx_q == PW'(N - 1)) ? '0 : grant_idx_q + PW'(1);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    grant_idx_d = grant_idx_q;
    valid_d     = valid_q;
`ifdef RR_ARBITER_TIMEOUT_EN
    cnt_d       = cnt_q;
    timeout_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // ack is deliberately ignored here.
        if (pick_found) begin
          state_d     = GRANT;
          grant_d     = pick_onehot;
          grant_idx_d = pick_idx;
          valid_d     = 1'b1;
`ifdef RR_ARBITER_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      GRANT: begin
        // Only ack, the holder's own request bit and the hold limit matter here;
        // ack wins over a simultaneous drop or limit.
        if (ack) begin
          state_d     = IDLE;
          grant_d     = '0;
          grant_idx_d = '0;
          valid_d     = 1'b0;
          ptr_d       = ptr_inc;
        end else if (!req[grant_idx_q]) begin
          state_d     = IDLE;
          grant_d     = '0;
          grant_idx_d = '0;
          valid_d     = 1'b0;
        end
`ifdef RR_ARBITER_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // Last permitted cycle: revoke and move on as if acknowledged.
          state_d     = IDLE;
          grant_d     = '0;
          grant_idx_d = '0;
          valid_d     = 1'b0;
          ptr_d       = ptr_inc;
          timeout_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: begin
        state_d     = IDLE;
        grant_d     = '0;
        grant_idx_d = '0;
        valid_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      grant_idx_q <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
      valid_q     <= valid_d;
    end
  end

`ifdef RR_ARBITER_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign grant     = grant_q;
  assign grant_idx = grant_idx_q;
  assign valid     = valid_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// tb/tb_rr_arbiter.sv - directed self-checking bench for rr_arbiter (N=4, TIMEOUT=8)

module tb_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       ack;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       valid;
  logic       timeout;

  int n_cmp = 0;
  int n_bad = 0;

  rr_arbiter #(
    .N       (4),
    .TIMEOUT (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .ack       (ack),
    .grant     (grant),
    .grant_idx (grant_idx),
    .valid     (valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    ack = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b0000;
    ack = 1'b0;
    #2;
    n_cmp++;
    if (grant !== 4'b0000 || grant_idx !== 2'd0 || valid !== 1'b0 || timeout !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: grant=%b idx=%0d valid=%b timeout=%b, want 0000/0/0/0",
               grant, grant_idx, valid, timeout);
    end
    req = 4'b1111;
    tick();
    tick();
    n_cmp++;
    if (grant !== 4'b0000 || valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_held: grant=%b valid=%b, want 0000/0", grant, valid);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (grant !== 4'b0001 || grant_idx !== 2'd0 || valid !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_first_grant: grant=%b idx=%0d valid=%b, want 0001/0/1",
               grant, grant_idx, valid);
    end
    // Hand the grant on so the pointer is non-zero, then reset mid-grant.
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    n_cmp++;
    if (grant !== 4'b0010 || grant_idx !== 2'd1) begin
      n_bad++;
      $display("FAIL reset_pre_grant: grant=%b idx=%0d, want 0010/1", grant, grant_idx);
    end
    #3;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (grant !== 4'b0000 || grant_idx !== 2'd0 || valid !== 1'b0 || timeout !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_async_mid_grant: grant=%b idx=%0d valid=%b timeout=%b, want 0000/0/0/0",
               grant, grant_idx, valid, timeout);
    end
    tick();
    rst = 1'b0;
    tick();
    n_cmp++;
    if (grant !== 4'b0001 || grant_idx !== 2'd0 || timeout !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_pointer_cleared: grant=%b idx=%0d timeout=%b, want 0001/0/0",
               grant, grant_idx, timeout);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_g [9];
    logic [1:0] exp_i [9];
    exp_g = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
    exp_i = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd3, 2'd0, 2'd0};
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 9; i++) begin
      ack = (i > 0) && (exp_g[i-1] != 4'b0000);
      tick();
      n_cmp++;
      if (grant !== exp_g[i] || grant_idx !== exp_i[i] || valid !== (exp_g[i] != 4'b0000)) begin
        n_bad++;
        $display("FAIL rotation[%0d]: grant=%b idx=%0d valid=%b, want %b/%0d/%b",
                 i, grant, grant_idx, valid, exp_g[i], exp_i[i], exp_g[i] != 4'b0000);
      end
    end
    ack = 1'b0;
  endtask

  task automatic test_wrap();
    logic [3:0] exp_g [5];
    logic [1:0] exp_i [5];
    exp_g = '{4'b0010, 4'b0000, 4'b1000, 4'b0000, 4'b0010};
    exp_i = '{2'd1, 2'd0, 2'd3, 2'd0, 2'd1};
    do_reset();
    req = 4'b1010;
    for (int i = 0; i < 5; i++) begin
      ack = (i > 0) && (exp_g[i-1] != 4'b0000);
      tick();
      n_cmp++;
      if (grant !== exp_g[i] || grant_idx !== exp_i[i]) begin
        n_bad++;
        $display("FAIL wrap[%0d]: grant=%b idx=%0d, want %b/%0d",
                 i, grant, grant_idx, exp_g[i], exp_i[i]);
      end
    end
    ack = 1'b0;
  endtask

  task automatic test_drop();
    do_reset();
    req = 4'b1111;
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    n_cmp++;
    if (grant !== 4'b0100 || grant_idx !== 2'd2) begin
      n_bad++;
      $display("FAIL drop_setup: grant=%b idx=%0d, want 0100/2", grant, grant_idx);
    end
    req = 4'b0000;
    tick();
    n_cmp++;
    if (grant !== 4'b0000 || valid !== 1'b0 || timeout !== 1'b0) begin
      n_bad++;
      $display("FAIL drop_withdraw: grant=%b valid=%b timeout=%b, want 0000/0/0",
               grant, valid, timeout);
    end
    req = 4'b1111;
    tick();
    n_cmp++;
    if (grant !== 4'b0100 || grant_idx !== 2'd2) begin
      n_bad++;
      $display("FAIL drop_pointer_kept: grant=%b idx=%0d, want 0100/2", grant, grant_idx);
    end
  endtask

  // Continues from test_drop: channel 2 holds the grant.
  task automatic test_ack_drop();
    ack = 1'b1;
    req = 4'b0000;
    tick();
    n_cmp++;
    if (grant !== 4'b0000 || valid !== 1'b0) begin
      n_bad++;
      $display("FAIL ack_drop_release: grant=%b valid=%b, want 0000/0", grant, valid);
    end
    ack = 1'b0;
    req = 4'b1111;
    tick();
    n_cmp++;
    if (grant !== 4'b1000 || grant_idx !== 2'd3) begin
      n_bad++;
      $display("FAIL ack_drop_advance: grant=%b idx=%0d, want 1000/3", grant, grant_idx);
    end
  endtask

  // Continues from test_ack_drop: channel 3 holds the grant.
  task automatic test_other_reqs();
    logic [3:0] pats [4];
    pats = '{4'b1001, 4'b1100, 4'b1010, 4'b1000};
    for (int i = 0; i < 4; i++) begin
      req = pats[i];
      tick();
      n_cmp++;
      if (grant !== 4'b1000 || grant_idx !== 2'd3 || valid !== 1'b1) begin
        n_bad++;
        $display("FAIL other_reqs[%0d]: grant=%b idx=%0d valid=%b, want 1000/3/1",
                 i, grant, grant_idx, valid);
      end
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    n_cmp++;
    if (grant !== 4'b0000) begin
      n_bad++;
      $display("FAIL other_reqs_ack: grant=%b, want 0000", grant);
    end
  endtask

  // Continues with pointer wrapped to 0 after channel 3 was acknowledged.
  task automatic test_idle_ack();
    req = 4'b0000;
    ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (grant !== 4'b0000 || valid !== 1'b0) begin
        n_bad++;
        $display("FAIL idle_ack[%0d]: grant=%b valid=%b, want 0000/0", i, grant, valid);
      end
    end
    ack = 1'b0;
    req = 4'b1111;
    tick();
    n_cmp++;
    if (grant !== 4'b0001 || grant_idx !== 2'd0) begin
      n_bad++;
      $display("FAIL idle_ack_pointer: grant=%b idx=%0d, want 0001/0", grant, grant_idx);
    end
  endtask

  task automatic test_hold();
    do_reset();
    req = 4'b0001;
    tick();
    n_cmp++;
    if (grant !== 4'b0001 || timeout !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_first: grant=%b timeout=%b, want 0001/0", grant, timeout);
    end
`ifdef RR_ARBITER_TIMEOUT_EN
    for (int i = 1; i < 8; i++) begin
      tick();
      n_cmp++;
      if (grant !== 4'b0001 || timeout !== 1'b0) begin
        n_bad++;
        $display("FAIL timeout_hold[%0d]: grant=%b timeout=%b, want 0001/0", i, grant, timeout);
      end
    end
    tick();
    n_cmp++;
    if (grant !== 4'b0000 || valid !== 1'b0 || timeout !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout_revoke: grant=%b valid=%b timeout=%b, want 0000/0/1",
               grant, valid, timeout);
    end
    tick();
    n_cmp++;
    if (grant !== 4'b0001 || timeout !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_regrant: grant=%b timeout=%b, want 0001/0", grant, timeout);
    end
    for (int i = 1; i < 8; i++) begin
      tick();
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    n_cmp++;
    if (grant !== 4'b0000 || timeout !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_ack_wins: grant=%b timeout=%b, want 0000/0", grant, timeout);
    end
`else
    for (int i = 0; i < 110; i++) begin
      tick();
      n_cmp++;
      if (grant !== 4'b0001 || valid !== 1'b1 || timeout !== 1'b0) begin
        n_bad++;
        $display("FAIL hold_forever[%0d]: grant=%b valid=%b timeout=%b, want 0001/1/0",
                 i, grant, valid, timeout);
      end
    end
`endif
    req = 4'b0000;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    ack = 1'b0;
    test_reset();
    test_rotation();
    test_wrap();
    test_drop();
    test_ack_drop();
    test_other_reqs();
    test_idle_ack();
    test_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 Parameter N, default 4: number of request channels; legal range 2..16.
REQ-002 Parameter TIMEOUT, default 8: grant-hold limit in cycles; legal range 2..255; used only with RR_ARBITER_TIMEOUT_EN.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req  input  N  per-channel request, level-sensitive.
REQ-006 ack  input  1  grant-holder consumed its grant; meaningful only while valid=1.
REQ-007 grant  output  N  one-hot grant, all-zero when no grant.
REQ-008 grant_idx  output  clog2(N)  binary index of granted channel, 0 when no grant.
REQ-009 valid  output  1  high exactly when grant is non-zero.
REQ-010 timeout  output  1  one-cycle pulse on forced grant revocation.

Function
REQ-011 FSM states: IDLE (no grant), GRANT (one channel granted); only these two.
REQ-012 grant, grant_idx, valid and timeout shall be registered outputs.
REQ-013 In IDLE with req != 0 at a rising edge, state goes to GRANT; the winner is the first set bit of req at or above pointer, searching upward with wrap from N-1 to 0.
REQ-014 Latency: grant appears the cycle after req is sampled; in IDLE with req = 0, no grant occurs.
REQ-015 pointer is clog2(N) bits; on ack it becomes (grant_idx+1) mod N.
REQ-016 In GRANT with ack=1 at an edge: grant clears, state returns to IDLE, and pointer advances; this costs one bubble cycle between grants.
REQ-017 In GRANT with ack=0 and req[grant_idx]=0: grant is withdrawn, state returns to IDLE, and pointer is unchanged.
REQ-018 Simultaneous ack=1 and req[grant_idx]=0 is treated as ack: pointer advances.
REQ-019 ack while in IDLE shall be ignored.
REQ-020 Changes to req bits other than grant_idx shall have no effect while in GRANT.
REQ-021 grant shall never have more than one bit set.

Reset
REQ-022 While rst=1, asynchronously: state=IDLE, pointer=0, grant=0, grant_idx=0, valid=0, timeout=0, hold counter=0.
REQ-023 Reset asserted mid-GRANT shall drop the grant immediately, with no timeout pulse and no pointer update.
REQ-024 First arbitration after reset release starts search at channel 0.

Configuration
REQ-025 Macro RR_ARBITER_TIMEOUT_EN defined: an 8-bit hold counter clears on entry to GRANT and increments each cycle in GRANT.
REQ-026 With the macro, reaching TIMEOUT cycles in GRANT without ack or drop shall revoke the grant, return to IDLE, advance pointer as for ack, and pulse timeout for exactly one cycle.
REQ-027 With the macro, ack in the same cycle the limit is reached takes precedence: no timeout pulse.
REQ-028 Macro undefined: no hold counter is implemented, timeout is tied to 0, and a grant is held indefinitely until ack or drop.

Structure
REQ-029 Shared package rr_arbiter_pkg shall hold the state enum (IDLE, GRANT) and constant N_MAX=16.
REQ-030 Sub-module rr_pick shall hold the combinational rotate-priority search: inputs req and pointer; outputs found, idx and one-hot.
REQ-031 rr_arbiter shall hold the FSM, pointer, counter and output registers only.

Verification (N=4, TIMEOUT=8)
REQ-032 rst pulse at any time -> all outputs 0 within the same cycle; first grant after release with req=4'b1111 is 4'b0001.
REQ-033 req=4'b1111 held, ack one cycle after each grant -> grants 0001, 0010, 0100, 1000, 0001, each separated by one idle cycle.
REQ-034 pointer=0, req=4'b1010 -> grant 0010 and grant_idx=1; after ack -> grant 1000 and grant_idx=3; after ack -> grant 0010 (wrap).
REQ-035 grant 0100 active, req drops to 4'b0000 with ack=0 -> next cycle grant=0, valid=0; next req=4'b1111 -> grant 0100 (pointer unchanged at 2).
REQ-036 Macro defined, req=4'b0001 held, no ack -> grant held 8 cycles, then cleared with timeout=1 for one cycle, then regranted 0001 after one idle cycle; macro undefined -> grant held for 100+ cycles and timeout stays 0.
REQ-037 ack and req[grant_idx] drop in the same cycle -> pointer advances (next grant with req=4'b1111 is grant_idx+1).
